// File: rtl/iob_rom_streamer_pkg.sv
// Shared types and constants for the ROM read streamer.
package iob_rom_streamer_pkg;

    // Burst sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Words held between ROM capture and downstream handshake.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/iob_rom_stream_buf.sv
// Two-entry first-word-fall-through buffer holding {last, data} words.
// A push and a pop in the same cycle are accepted even when full.
module iob_rom_stream_buf
    import iob_rom_streamer_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       occupancy,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == 2'(BUF_DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign pop_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    // Next pointer and occupancy values from the push/pop pair.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            // NOTE: the two storage words are reset so the stream outputs read 0 during reset; a large RAM would not be reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/iob_rom_streamer.sv
// Burst read sequencer in front of iob_sp_rom: issues ROM reads, captures
// the data one cycle later and re-emits it as a valid/ready stream with last.
module iob_rom_streamer
    import iob_rom_streamer_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_r_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic [DATA_W:0]   buf_pop_data;
    logic [1:0]        buf_occupancy;
    logic              buf_empty;
    logic              pop;
    logic              issue;
    logic [2:0]        outstanding;

    // Buffered words plus the read whose data arrives this cycle.
    assign outstanding = 3'(buf_occupancy) + 3'(inflight_q);
    assign pop         = m_valid && m_ready;
    // A word leaving this cycle frees a slot, so m_ready feeds rom_r_en directly.
    assign issue       = (state_q == RUN) && (remaining_q != '0) &&
                         (outstanding < (3'd2 + 3'(pop)));

    assign rom_r_en = issue;
    assign rom_addr = issue ? addr_q : rom_addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign m_valid  = !buf_empty;
    assign m_data   = buf_pop_data[DATA_W-1:0];
    assign m_last   = m_valid && buf_pop_data[DATA_W];

    iob_rom_stream_buf #(
        .WIDTH(DATA_W + 1)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, rom_r_data}),
        .pop       (pop),
        .pop_data  (buf_pop_data),
        .occupancy (buf_occupancy),
        .empty     (buf_empty)
    );

    // Next-state logic for the sequencer and its address/length counters.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rom_addr_d      = rom_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LEN_W'(1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = RUN;
                        addr_d      = start_addr;
                        remaining_d = len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    rom_addr_d  = addr_q;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (buf_empty && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and counter registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rom_addr_q      <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rom_addr_q      <= rom_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

endmodule

// File: tb/tb_iob_rom_streamer.sv
// Scoreboard bench for iob_rom_streamer with a behavioural synchronous ROM.
module tb_iob_rom_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  start_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic        rom_r_en;
    logic [9:0]  rom_addr;
    logic [7:0]  rom_r_data = 8'h00;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [7:0]  m_data;
    logic        m_last;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc;
    bit ready_mode = 1'b0;

    logic [9:0] exp_addr [$];
    logic [8:0] exp_word [$];

    int en_cnt, valid_cnt, en_run, max_run, n_acc;
    int issued, accepted, max_out;
    bit prev_stall, prev_done;
    logic [8:0] prev_word;

    iob_rom_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_r_en   (rom_r_en),
        .rom_addr   (rom_addr),
        .rom_r_data (rom_r_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ROM contents: a fixed scrambled pattern of the address.
    function automatic logic [7:0] rom_word(input logic [9:0] a);
        logic [9:0] t;
        t = (a * 10'd7) ^ (a >> 3) ^ 10'h0A5;
        return t[7:0];
    endfunction

    // Synchronous ROM: data appears the cycle after r_en.
    always @(posedge clk) if (rom_r_en) rom_r_data <= rom_word(rom_addr);

    // Downstream ready: held high, or a fair coin per cycle.
    always @(posedge clk) begin
        #1;
        m_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares addresses and stream words against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            issued = 0; accepted = 0; prev_stall = 0; prev_done = 0; en_run = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(m_valid), 32'd1);
                check("stall_word_held", 32'({m_last, m_data}), 32'(prev_word));
            end
            if (prev_done) check("busy_done_after_done", 32'({busy, done}), 32'd0);
            if (rom_r_en) begin
                en_cnt++; en_run++; issued++;
                if (en_run > max_run) max_run = en_run;
                if (exp_addr.size() == 0) fail_now($sformatf("rom_addr unexpected read of 0x%0h", rom_addr));
                else check("rom_addr", 32'(rom_addr), 32'(exp_addr.pop_front()));
            end else begin
                en_run = 0;
            end
            if (m_valid) valid_cnt++;
            if (m_valid && m_ready) begin
                accepted++; n_acc++;
                if (exp_word.size() == 0) fail_now($sformatf("m_word unexpected word 0x%0h", {m_last, m_data}));
                else check("m_word {last,data}", 32'({m_last, m_data}), 32'(exp_word.pop_front()));
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
            prev_done  = done;
        end
    end

    task automatic push_expected(input logic [9:0] addr, input int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 10'(i);
            exp_addr.push_back(a);
            exp_word.push_back({i == n - 1, rom_word(a)});
        end
    endtask

    task automatic pulse_start(input logic [9:0] addr, input logic [10:0] n);
        @(posedge clk); #1;
        start = 1'b1; start_addr = addr; len = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int delay);
        int k;
        k = 0;
        delay = -1;
        while (!done && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (done) delay = cyc - start_cyc;
        else fail_now("done timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int d;

    initial begin
        logic [9:0] wrap_list [4];
        wrap_list = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        rst = 1'b1; start = 1'b0; start_addr = '0; len = '0;
        en_cnt = 0; valid_cnt = 0; max_run = 0; n_acc = 0; max_out = 0;
        idle(3);
        check("reset outputs", 32'({busy, done, rom_r_en, m_valid, m_last, m_data, rom_addr}), 32'd0);
        rst = 1'b0;
        idle(2);

        // Full sweep of the ROM at full throughput.
        en_cnt = 0; max_run = 0;
        push_expected(10'h000, 1024);
        pulse_start(10'h000, 11'd1024);
        start_cyc = cyc;
        check("busy after start", 32'(busy), 32'd1);
        wait_done(2000, d);
        check("sweep done delay", d, 32'd1027);
        idle(3);
        check("sweep rom_r_en count", en_cnt, 32'd1024);
        check("sweep rom_r_en run", max_run, 32'd1024);
        check("sweep words left", exp_word.size(), 32'd0);

        // Backpressure with random ready.
        ready_mode = 1'b1; max_out = 0;
        push_expected(10'h010, 16);
        pulse_start(10'h010, 11'd16);
        start_cyc = cyc;
        wait_done(400, d);
        idle(3);
        ready_mode = 1'b0;
        idle(1);
        check("bp max outstanding<=2", 32'(max_out <= 2), 32'd1);
        check("bp words left", exp_word.size(), 32'd0);

        // Address wrap-around.
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(wrap_list[i]);
            exp_word.push_back({i == 3, rom_word(wrap_list[i])});
        end
        pulse_start(10'h3FE, 11'd4);
        start_cyc = cyc;
        wait_done(100, d);
        check("wrap done delay", d, 32'd7);
        idle(3);
        check("wrap addrs left", exp_addr.size(), 32'd0);

        // Zero-length burst.
        en_cnt = 0; valid_cnt = 0;
        pulse_start(10'h055, 11'd0);
        start_cyc = cyc;
        wait_done(10, d);
        check("zero-len done delay", d, 32'd0);
        idle(4);
        check("zero-len rom_r_en count", en_cnt, 32'd0);
        check("zero-len m_valid count", valid_cnt, 32'd0);

        // Start while busy is ignored.
        push_expected(10'h020, 8);
        pulse_start(10'h020, 11'd8);
        start_cyc = cyc;
        idle(2);
        start = 1'b1; start_addr = 10'h100; len = 11'd5;
        idle(1);
        start = 1'b0;
        wait_done(100, d);
        check("busy-start done delay", d, 32'd11);
        idle(4);
        check("busy-start words left", exp_word.size(), 32'd0);

        // Reset in the middle of a burst.
        push_expected(10'h040, 20);
        d = n_acc;
        pulse_start(10'h040, 11'd20);
        for (int k = 0; k < 50 && n_acc - d < 5; k++) idle(1);
        if (n_acc - d < 5) fail_now("mid-burst words timeout");
        rst = 1'b1;
        exp_addr.delete();
        exp_word.delete();
        #1;
        check("mid reset outputs", 32'({busy, done, rom_r_en, m_valid}), 32'd0);
        idle(1);
        check("mid reset outputs held", 32'({busy, done, rom_r_en, m_valid}), 32'd0);
        rst = 1'b0;
        idle(2);
        push_expected(10'h000, 3);
        pulse_start(10'h000, 11'd3);
        start_cyc = cyc;
        wait_done(100, d);
        check("post-reset done delay", d, 32'd6);
        idle(3);
        check("post-reset words left", exp_word.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
